// File: rtl/plic_claim_sequencer.sv
// ---------------------------------------------------------------------------
// plic_claim_sequencer
//
// Bus master that runs the PLIC claim/complete protocol for two interrupt
// contexts over an AXI-style read/write interface. A context with a pending
// interrupt line and no claim outstanding is granted (round-robin on ties).
// Its claim register is read, and a non-zero source ID is handed to a
// consumer. Completion requests from the consumer are written back to the
// context's claim/complete register. Only one bus transaction is in flight
// at a time, and completions take priority over new claims.
//
// Ports
//   M_AXI_ACLK, M_AXI_ARESET : clock, synchronous active-high reset
//   irq_ctx                  : per-context PLIC interrupt lines
//   M_AXI_AW* / W* / B*      : write channels (completion writes)
//   M_AXI_AR* / R*           : read channels (claim reads)
//   claim_*                  : claimed interrupt handoff to the consumer
//   done_*                   : completion requests from the consumer
//   ctx_busy                 : per-context claim outstanding
//   bus_err                  : sticky flag for any non-OKAY response
//   spurious_cnt             : saturating count of claims that returned ID 0
// ---------------------------------------------------------------------------
module plic_claim_sequencer #(
   parameter int                ADDR_W     = 28,
   parameter logic [ADDR_W-1:0] PLIC_BASE  = 28'h0000000,
   parameter logic [ADDR_W-1:0] CTX_STRIDE = 28'h1000
) (
   input  logic              M_AXI_ACLK,
   input  logic              M_AXI_ARESET,
   input  logic [1:0]        irq_ctx,
   output logic [ADDR_W-1:0] M_AXI_AWADDR,
   output logic              M_AXI_AWVALID,
   input  logic              M_AXI_AWREADY,
   output logic [63:0]       M_AXI_WDATA,
   output logic [7:0]        M_AXI_WSTRB,
   output logic              M_AXI_WVALID,
   input  logic              M_AXI_WREADY,
   input  logic [1:0]        M_AXI_BRESP,
   input  logic              M_AXI_BVALID,
   output logic              M_AXI_BREADY,
   output logic [ADDR_W-1:0] M_AXI_ARADDR,
   output logic              M_AXI_ARVALID,
   input  logic              M_AXI_ARREADY,
   input  logic [63:0]       M_AXI_RDATA,
   input  logic [1:0]        M_AXI_RRESP,
   input  logic              M_AXI_RVALID,
   output logic              M_AXI_RREADY,
   output logic              claim_valid,
   input  logic              claim_ready,
   output logic              claim_ctx,
   output logic [5:0]        claim_id,
   input  logic              done_valid,
   output logic              done_ready,
   input  logic              done_ctx,
   input  logic [5:0]        done_id,
   output logic [1:0]        ctx_busy,
   output logic              bus_err,
   output logic [7:0]        spurious_cnt
);

   typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, HANDOFF, WR_REQ, WR_RESP} state_t;

   // Context register blocks start at this offset; the claim/complete
   // register sits 4 bytes into each block.
   localparam logic [ADDR_W-1:0] CTX_BLK   = ADDR_W'(32'h0020_0000);
   localparam logic [ADDR_W-1:0] CLAIM_OFF = ADDR_W'(4);

   state_t            state_q, state_d;
   logic              rr_q, rr_d;
   logic              wr_ctx_q, wr_ctx_d;
   logic [ADDR_W-1:0] araddr_q, araddr_d;
   logic              arvalid_q, arvalid_d;
   logic              rready_q, rready_d;
   logic [ADDR_W-1:0] awaddr_q, awaddr_d;
   logic              awvalid_q, awvalid_d;
   logic [63:0]       wdata_q, wdata_d;
   logic [7:0]        wstrb_q, wstrb_d;
   logic              wvalid_q, wvalid_d;
   logic              bready_q, bready_d;
   logic              claim_valid_q, claim_valid_d;
   logic              claim_ctx_q, claim_ctx_d;
   logic [5:0]        claim_id_q, claim_id_d;
   logic [1:0]        busy_q, busy_d;
   logic              bus_err_q, bus_err_d;
   logic [7:0]        spurious_q, spurious_d;

   logic [1:0]        eligible;
   logic              grant;
   logic              accept_done;
   logic [5:0]        rd_id;
   logic              unused_rdata;

   assign rd_id        = M_AXI_RDATA[37:32];
   assign unused_rdata = ^{M_AXI_RDATA[63:38], M_AXI_RDATA[31:0]};

   // Completions are accepted only from IDLE and never while reset is held,
   // so a request seen during reset is not lost.
   assign accept_done = (state_q == IDLE) && done_valid && !M_AXI_ARESET;
   assign done_ready  = accept_done;

   function automatic logic [ADDR_W-1:0] ctx_base(input logic c);
      return PLIC_BASE + CTX_BLK + (c ? CTX_STRIDE : '0);
   endfunction

   always_comb begin
      state_d       = state_q;
      rr_d          = rr_q;
      wr_ctx_d      = wr_ctx_q;
      araddr_d      = araddr_q;
      arvalid_d     = arvalid_q;
      rready_d      = rready_q;
      awaddr_d      = awaddr_q;
      awvalid_d     = awvalid_q;
      wdata_d       = wdata_q;
      wstrb_d       = wstrb_q;
      wvalid_d      = wvalid_q;
      bready_d      = bready_q;
      claim_valid_d = claim_valid_q;
      claim_ctx_d   = claim_ctx_q;
      claim_id_d    = claim_id_q;
      busy_d        = busy_q;
      bus_err_d     = bus_err_q;
      spurious_d    = spurious_q;
      eligible      = irq_ctx & ~busy_q;
      grant         = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (accept_done) begin
               wr_ctx_d  = done_ctx;
               awaddr_d  = ctx_base(done_ctx);
               wdata_d   = {26'b0, done_id, 32'b0};
               wstrb_d   = 8'hF0;
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
               state_d   = WR_REQ;
            end else if (eligible != 2'b00) begin
               // rr_q holds the context that wins a tie: the one not granted last.
               grant       = (eligible == 2'b11) ? rr_q : eligible[1];
               rr_d        = ~grant;
               claim_ctx_d = grant;
               araddr_d    = ctx_base(grant) + CLAIM_OFF;
               arvalid_d   = 1'b1;
               state_d     = RD_ADDR;
            end
         end
         RD_ADDR: begin
            if (M_AXI_ARREADY) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = RD_DATA;
            end
         end
         RD_DATA: begin
            if (M_AXI_RVALID) begin
               rready_d = 1'b0;
               state_d  = IDLE;
               if (M_AXI_RRESP != 2'b00) begin
                  bus_err_d = 1'b1;
               end else if (rd_id == 6'd0) begin
                  if (spurious_q != 8'hFF) spurious_d = spurious_q + 8'd1;
               end else begin
                  busy_d[claim_ctx_q] = 1'b1;
                  claim_id_d          = rd_id;
                  claim_valid_d       = 1'b1;
                  state_d             = HANDOFF;
               end
            end
         end
         HANDOFF: begin
            if (claim_ready) begin
               claim_valid_d = 1'b0;
               state_d       = IDLE;
            end
         end
         WR_REQ: begin
            // AW and W retire independently; move on once both have gone.
            if (M_AXI_AWREADY) awvalid_d = 1'b0;
            if (M_AXI_WREADY)  wvalid_d  = 1'b0;
            if (!awvalid_d && !wvalid_d) begin
               bready_d = 1'b1;
               state_d  = WR_RESP;
            end
         end
         WR_RESP: begin
            if (M_AXI_BVALID) begin
               bready_d         = 1'b0;
               busy_d[wr_ctx_q] = 1'b0;
               if (M_AXI_BRESP != 2'b00) bus_err_d = 1'b1;
               state_d          = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge M_AXI_ACLK) begin
      if (M_AXI_ARESET) begin
         state_q       <= IDLE;
         rr_q          <= 1'b0;
         wr_ctx_q      <= 1'b0;
         araddr_q      <= '0;
         arvalid_q     <= 1'b0;
         rready_q      <= 1'b0;
         awaddr_q      <= '0;
         awvalid_q     <= 1'b0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         wvalid_q      <= 1'b0;
         bready_q      <= 1'b0;
         claim_valid_q <= 1'b0;
         claim_ctx_q   <= 1'b0;
         claim_id_q    <= '0;
         busy_q        <= '0;
         bus_err_q     <= 1'b0;
         spurious_q    <= '0;
      end else begin
         state_q       <= state_d;
         rr_q          <= rr_d;
         wr_ctx_q      <= wr_ctx_d;
         araddr_q      <= araddr_d;
         arvalid_q     <= arvalid_d;
         rready_q      <= rready_d;
         awaddr_q      <= awaddr_d;
         awvalid_q     <= awvalid_d;
         wdata_q       <= wdata_d;
         wstrb_q       <= wstrb_d;
         wvalid_q      <= wvalid_d;
         bready_q      <= bready_d;
         claim_valid_q <= claim_valid_d;
         claim_ctx_q   <= claim_ctx_d;
         claim_id_q    <= claim_id_d;
         busy_q        <= busy_d;
         bus_err_q     <= bus_err_d;
         spurious_q    <= spurious_d;
      end
   end

   assign M_AXI_ARADDR  = araddr_q;
   assign M_AXI_ARVALID = arvalid_q;
   assign M_AXI_RREADY  = rready_q;
   assign M_AXI_AWADDR  = awaddr_q;
   assign M_AXI_AWVALID = awvalid_q;
   assign M_AXI_WDATA   = wdata_q;
   assign M_AXI_WSTRB   = wstrb_q;
   assign M_AXI_WVALID  = wvalid_q;
   assign M_AXI_BREADY  = bready_q;
   assign claim_valid   = claim_valid_q;
   assign claim_ctx     = claim_ctx_q;
   assign claim_id      = claim_id_q;
   assign ctx_busy      = busy_q;
   assign bus_err       = bus_err_q;
   assign spurious_cnt  = spurious_q;

endmodule

// File: tb/tb_plic_claim_sequencer.sv
// ---------------------------------------------------------------------------
// tb_plic_claim_sequencer
//
// Directed scenarios plus a randomized run against a small model of the
// claim/complete rules (busy set per context, tie-break preference, sticky
// error, saturating spurious count). The bench plays the AXI slave and the
// interrupt consumer.
// ---------------------------------------------------------------------------
module tb_plic_claim_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  irq_ctx = '0;
   logic [27:0] awaddr;
   logic        awvalid;
   logic        awready = 1'b0;
   logic [63:0] wdata;
   logic [7:0]  wstrb;
   logic        wvalid;
   logic        wready = 1'b0;
   logic [1:0]  bresp = '0;
   logic        bvalid = 1'b0;
   logic        bready;
   logic [27:0] araddr;
   logic        arvalid;
   logic        arready = 1'b0;
   logic [63:0] rdata = '0;
   logic [1:0]  rresp = '0;
   logic        rvalid = 1'b0;
   logic        rready;
   logic        claim_valid;
   logic        claim_ready = 1'b0;
   logic        claim_ctx;
   logic [5:0]  claim_id;
   logic        done_valid = 1'b0;
   logic        done_ready;
   logic        done_ctx = 1'b0;
   logic [5:0]  done_id = '0;
   logic [1:0]  ctx_busy;
   logic        bus_err;
   logic [7:0]  spurious_cnt;

   int checks = 0;
   int errors = 0;

   plic_claim_sequencer dut (
      .M_AXI_ACLK(clk), .M_AXI_ARESET(rst), .irq_ctx(irq_ctx),
      .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
      .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
      .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
      .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
      .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
      .claim_valid(claim_valid), .claim_ready(claim_ready), .claim_ctx(claim_ctx), .claim_id(claim_id),
      .done_valid(done_valid), .done_ready(done_ready), .done_ctx(done_ctx), .done_id(done_id),
      .ctx_busy(ctx_busy), .bus_err(bus_err), .spurious_cnt(spurious_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      irq_ctx = '0; awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
      claim_ready = 0; done_valid = 0;
      repeat (2) tick;
      rst = 1'b0;
   endtask

   // Plays the AXI read slave for one claim read.
   task automatic serve_read(input logic [63:0] data, input logic [1:0] resp,
                             input int ar_delay, input int r_delay,
                             output logic [27:0] addr, output int ar_wait, output bit ok);
      ok = 1; ar_wait = 0; addr = '0;
      for (int i = 1; i <= 20; i++) begin
         tick;
         if (arvalid) begin ar_wait = i; break; end
      end
      if (ar_wait == 0) begin ok = 0; return; end
      for (int i = 0; i < ar_delay; i++) begin
         tick;
         if (!arvalid || araddr !== addr && i > 0) ok = 0;
         addr = araddr;
      end
      addr = araddr;
      arready = 1'b1;
      tick;
      arready = 1'b0;
      if (arvalid) ok = 0;
      for (int i = 0; i < r_delay; i++) tick;
      if (!rready) ok = 0;
      rvalid = 1'b1; rdata = data; rresp = resp;
      tick;
      rvalid = 1'b0; rdata = '0; rresp = '0;
   endtask

   // Plays the consumer accepting one claim handoff.
   task automatic take_claim(input int delay, output logic ctx, output logic [5:0] id, output bit ok);
      bit seen = 0;
      ok = 1; ctx = 0; id = 0;
      for (int i = 0; i < 20; i++) begin
         if (claim_valid) begin seen = 1; break; end
         tick;
      end
      if (!seen) begin ok = 0; return; end
      ctx = claim_ctx; id = claim_id;
      for (int i = 0; i < delay; i++) begin
         tick;
         if (!claim_valid || claim_ctx !== ctx || claim_id !== id) ok = 0;
      end
      claim_ready = 1'b1;
      tick;
      claim_ready = 1'b0;
      if (claim_valid) ok = 0;
   endtask

   // Plays the consumer issuing one completion request.
   task automatic send_done(input logic c, input logic [5:0] id, output bit ok);
      ok = 0;
      done_valid = 1'b1; done_ctx = c; done_id = id;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (done_ready) begin
            ok = 1;
            @(posedge clk); #1;
            break;
         end
         @(posedge clk); #1;
      end
      done_valid = 1'b0;
   endtask

   // Plays the AXI write slave for one completion write.
   task automatic serve_write(input int aw_delay, input int w_delay, input int b_delay,
                              input logic [1:0] bresp_in,
                              output logic [27:0] addr, output logic [63:0] data,
                              output logic [7:0] strb, output int awc, output int wc,
                              output bit ok);
      ok = 0; awc = 0; wc = 0; addr = '0; data = '0; strb = '0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (bready) begin
            awready = 1'b0; wready = 1'b0;
            for (int i = 0; i < b_delay; i++) tick;
            bvalid = 1'b1; bresp = bresp_in;
            tick;
            bvalid = 1'b0; bresp = '0;
            ok = !bready;
            break;
         end
         awready = awvalid && (cyc >= aw_delay);
         wready  = wvalid && (cyc >= w_delay);
         if (awready) begin awc++; addr = awaddr; end
         if (wready)  begin wc++; data = wdata; strb = wstrb; end
         tick;
      end
      awready = 1'b0; wready = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) tick;
      checks++;
      if ({arvalid, rready, awvalid, wvalid, bready, claim_valid, done_ready} !== 7'b0) begin
         errors++;
         $display("[TB] FAIL reset_handshakes: got %b expected %b",
                  {arvalid, rready, awvalid, wvalid, bready, claim_valid, done_ready}, 7'b0);
      end
      checks++;
      if ({ctx_busy, bus_err, spurious_cnt} !== 11'b0) begin
         errors++;
         $display("[TB] FAIL reset_status: got %h expected %h", {ctx_busy, bus_err, spurious_cnt}, 11'h0);
      end
      checks++;
      if ({araddr, awaddr, wdata, wstrb} !== 128'b0) begin
         errors++;
         $display("[TB] FAIL reset_addr_data: got %h expected 0", {araddr, awaddr, wdata, wstrb});
      end
      rst = 1'b0;
      repeat (2) tick;
      checks++;
      if ({arvalid, awvalid, wvalid, claim_valid} !== 4'b0) begin
         errors++;
         $display("[TB] FAIL idle_quiet: got %b expected 0000", {arvalid, awvalid, wvalid, claim_valid});
      end
   endtask

   task automatic test_single_claim;
      logic [27:0] a; int w; bit ok; logic c; logic [5:0] id;
      irq_ctx = 2'b01;
      serve_read(64'h0000000E_00000000, 2'b00, 2, 1, a, w, ok);
      irq_ctx = 2'b00;
      checks++;
      if (!ok || w != 1) begin
         errors++;
         $display("[TB] FAIL claim0_read_handshake: got ok=%0d latency=%0d expected ok=1 latency=1", ok, w);
      end
      checks++;
      if (a !== 28'h0200004) begin
         errors++;
         $display("[TB] FAIL claim0_araddr: got %h expected %h", a, 28'h0200004);
      end
      checks++;
      if (claim_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL claim0_valid_latency: got %b expected 1", claim_valid);
      end
      take_claim(2, c, id, ok);
      checks++;
      if (!ok || c !== 1'b0 || id !== 6'd14) begin
         errors++;
         $display("[TB] FAIL claim0_handoff: got ok=%0d ctx=%0d id=%0d expected ok=1 ctx=0 id=14", ok, c, id);
      end
      checks++;
      if (ctx_busy !== 2'b01) begin
         errors++;
         $display("[TB] FAIL claim0_busy: got %b expected 01", ctx_busy);
      end
   endtask

   task automatic test_complete;
      bit ok; logic [27:0] a; logic [63:0] d; logic [7:0] s; int awc, wc;
      send_done(1'b0, 6'd14, ok);
      checks++;
      if (!ok || {awvalid, wvalid} !== 2'b11) begin
         errors++;
         $display("[TB] FAIL done_accept_latency: got ok=%0d aw/w=%b expected ok=1 aw/w=11", ok, {awvalid, wvalid});
      end
      serve_write(0, 0, 1, 2'b00, a, d, s, awc, wc, ok);
      checks++;
      if (!ok || a !== 28'h0200000 || d !== 64'h0000000E_00000000 || s !== 8'hF0) begin
         errors++;
         $display("[TB] FAIL complete_write: got ok=%0d addr=%h data=%h strb=%h expected ok=1 addr=0200000 data=0000000e00000000 strb=f0",
                  ok, a, d, s);
      end
      checks++;
      if (awc != 1 || wc != 1 || ctx_busy !== 2'b00) begin
         errors++;
         $display("[TB] FAIL complete_counts_busy: got aw=%0d w=%0d busy=%b expected aw=1 w=1 busy=00", awc, wc, ctx_busy);
      end
   endtask

   task automatic test_round_robin;
      logic [27:0] a0, a1; int w; bit ok0, ok1, ok2, ok3; logic c0, c1; logic [5:0] i0, i1;
      do_reset;
      irq_ctx = 2'b11;
      serve_read(64'h00000003_00000000, 2'b00, 0, 0, a0, w, ok0);
      take_claim(0, c0, i0, ok1);
      serve_read(64'h00000003_00000000, 2'b00, 1, 2, a1, w, ok2);
      take_claim(1, c1, i1, ok3);
      irq_ctx = 2'b00;
      checks++;
      if (!(ok0 && ok1 && ok2 && ok3) || a0 !== 28'h0200004 || a1 !== 28'h0201004) begin
         errors++;
         $display("[TB] FAIL rr_read_order: got ok=%0d%0d%0d%0d addr0=%h addr1=%h expected ok=1111 addr0=0200004 addr1=0201004",
                  ok0, ok1, ok2, ok3, a0, a1);
      end
      checks++;
      if (c0 !== 1'b0 || c1 !== 1'b1 || i0 !== 6'd3 || i1 !== 6'd3 || ctx_busy !== 2'b11) begin
         errors++;
         $display("[TB] FAIL rr_handoffs: got ctx=%0d,%0d id=%0d,%0d busy=%b expected ctx=0,1 id=3,3 busy=11",
                  c0, c1, i0, i1, ctx_busy);
      end
   endtask

   task automatic test_spurious;
      logic [27:0] a; int w; bit ok; bit all_ok = 1;
      do_reset;
      irq_ctx = 2'b01;
      serve_read(64'h0, 2'b00, 0, 0, a, w, ok);
      irq_ctx = 2'b00;
      checks++;
      if (!ok || claim_valid !== 1'b0 || spurious_cnt !== 8'd1 || ctx_busy !== 2'b00) begin
         errors++;
         $display("[TB] FAIL spurious_single: got ok=%0d cv=%b cnt=%0d busy=%b expected ok=1 cv=0 cnt=1 busy=00",
                  ok, claim_valid, spurious_cnt, ctx_busy);
      end
      for (int n = 0; n < 259; n++) begin
         irq_ctx = 2'b01;
         serve_read(64'h0, 2'b00, 0, 0, a, w, ok);
         irq_ctx = 2'b00;
         if (!ok) all_ok = 0;
      end
      checks++;
      if (!all_ok || spurious_cnt !== 8'd255) begin
         errors++;
         $display("[TB] FAIL spurious_saturate: got ok=%0d cnt=%0d expected ok=1 cnt=255", all_ok, spurious_cnt);
      end
   endtask

   task automatic test_bus_err;
      logic [27:0] a; int w; bit ok; logic [63:0] d; logic [7:0] s; int awc, wc; bit ok2;
      do_reset;
      irq_ctx = 2'b01;
      serve_read(64'h00000005_00000000, 2'b10, 0, 1, a, w, ok);
      irq_ctx = 2'b00;
      tick;
      checks++;
      if (!ok || claim_valid !== 1'b0 || bus_err !== 1'b1 || ctx_busy !== 2'b00) begin
         errors++;
         $display("[TB] FAIL rresp_error: got ok=%0d cv=%b err=%b busy=%b expected ok=1 cv=0 err=1 busy=00",
                  ok, claim_valid, bus_err, ctx_busy);
      end
      send_done(1'b1, 6'd9, ok);
      serve_write(3, 0, 0, 2'b00, a, d, s, awc, wc, ok2);
      checks++;
      if (!ok || !ok2 || awc != 1 || wc != 1) begin
         errors++;
         $display("[TB] FAIL w_before_aw_counts: got ok=%0d%0d aw=%0d w=%0d expected ok=11 aw=1 w=1", ok, ok2, awc, wc);
      end
      checks++;
      if (a !== 28'h0201000 || d !== (64'(9) << 32) || s !== 8'hF0 || ctx_busy !== 2'b00) begin
         errors++;
         $display("[TB] FAIL w_before_aw_write: got addr=%h data=%h strb=%h busy=%b expected addr=0201000 data=%h strb=f0 busy=00",
                  a, d, s, ctx_busy, 64'(9) << 32);
      end
   endtask

   task automatic test_reset_mid;
      logic [27:0] a; int w; bit ok, ok2, seen; logic c; logic [5:0] id;
      do_reset;
      irq_ctx = 2'b11;
      serve_read(64'h00000007_00000000, 2'b00, 0, 0, a, w, ok);
      take_claim(0, c, id, ok2);
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         if (arvalid) begin seen = 1; break; end
         tick;
      end
      arready = 1'b1;
      tick;
      arready = 1'b0;
      irq_ctx = 2'b00;
      checks++;
      if (!ok || !ok2 || !seen || rready !== 1'b1 || ctx_busy !== 2'b01) begin
         errors++;
         $display("[TB] FAIL midreset_setup: got ok=%0d%0d%0d rready=%b busy=%b expected ok=111 rready=1 busy=01",
                  ok, ok2, seen, rready, ctx_busy);
      end
      rst = 1'b1;
      tick;
      rst = 1'b0;
      checks++;
      if ({arvalid, rready, awvalid, wvalid, bready, claim_valid, done_ready} !== 7'b0 || ctx_busy !== 2'b00) begin
         errors++;
         $display("[TB] FAIL midreset_cleared: got hs=%b busy=%b expected hs=0000000 busy=00",
                  {arvalid, rready, awvalid, wvalid, bready, claim_valid, done_ready}, ctx_busy);
      end
      rvalid = 1'b1; rdata = 64'h00000007_00000000;
      tick;
      rvalid = 1'b0; rdata = '0;
      tick;
      checks++;
      if (claim_valid !== 1'b0 || ctx_busy !== 2'b00) begin
         errors++;
         $display("[TB] FAIL midreset_no_handoff: got cv=%b busy=%b expected cv=0 busy=00", claim_valid, ctx_busy);
      end
      irq_ctx = 2'b01;
      tick;
      irq_ctx = 2'b00;
      checks++;
      if (arvalid !== 1'b1 || araddr !== 28'h0200004) begin
         errors++;
         $display("[TB] FAIL midreset_idle_grant: got arvalid=%b addr=%h expected arvalid=1 addr=0200004", arvalid, araddr);
      end
   endtask

   // Randomized run. The model tracks only what the rules define: which
   // contexts hold a claim, which context wins the next tie, the sticky error
   // and the saturating spurious count.
   task automatic test_random;
      bit busy_m [2];
      int pref_m = 0;
      int spur_m = 0;
      bit err_m  = 0;
      do_reset;
      busy_m[0] = 0; busy_m[1] = 0;
      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 2) == 0) begin
            bit ok, ok2; logic [27:0] a; logic [63:0] d; logic [7:0] s; int awc, wc;
            int c = $urandom_range(0, 1);
            int id = $urandom_range(0, 63);
            logic [1:0] br = ($urandom_range(0, 15) == 0) ? 2'b10 : 2'b00;
            send_done(c[0], 6'(id), ok);
            serve_write($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), br, a, d, s, awc, wc, ok2);
            checks++;
            if (!ok || !ok2 || awc != 1 || wc != 1 || a !== 28'(32'h200000 + c * 32'h1000) ||
                d !== (64'(id) << 32) || s !== 8'hF0) begin
               errors++;
               $display("[TB] FAIL rand_write[%0d]: got ok=%0d%0d aw=%0d w=%0d addr=%h data=%h strb=%h expected ctx=%0d id=%0d",
                        n, ok, ok2, awc, wc, a, d, s, c, id);
            end
            busy_m[c] = 0;
            if (br != 2'b00) err_m = 1;
         end else begin
            int irq = $urandom_range(0, 3);
            int e0 = (irq % 2 == 1) && !busy_m[0];
            int e1 = (irq / 2 == 1) && !busy_m[1];
            irq_ctx = 2'(irq);
            if (!e0 && !e1) begin
               bit stray = 0;
               repeat (3) begin tick; if (arvalid) stray = 1; end
               irq_ctx = 2'b00;
               checks++;
               if (stray) begin
                  errors++;
                  $display("[TB] FAIL rand_no_grant[%0d]: got arvalid=1 expected 0 (irq=%0d)", n, irq);
               end
            end else begin
               logic [27:0] a; int w; bit ok;
               int g = (e0 && e1) ? pref_m : (e1 ? 1 : 0);
               int id = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 63);
               logic [1:0] rr = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
               pref_m = 1 - g;
               serve_read(64'(id) << 32, rr, $urandom_range(0, 3), $urandom_range(0, 3), a, w, ok);
               irq_ctx = 2'b00;
               checks++;
               if (!ok || w != 1 || a !== 28'(32'h200004 + g * 32'h1000)) begin
                  errors++;
                  $display("[TB] FAIL rand_read[%0d]: got ok=%0d latency=%0d addr=%h expected ok=1 latency=1 ctx=%0d",
                           n, ok, w, a, g);
               end
               if (rr != 2'b00 || id == 0) begin
                  if (rr != 2'b00) err_m = 1;
                  else if (spur_m < 255) spur_m++;
                  checks++;
                  if (claim_valid !== 1'b0) begin
                     errors++;
                     $display("[TB] FAIL rand_no_handoff[%0d]: got claim_valid=%b expected 0", n, claim_valid);
                  end
               end else begin
                  logic c; logic [5:0] cid; bit ok2;
                  busy_m[g] = 1;
                  take_claim($urandom_range(0, 3), c, cid, ok2);
                  checks++;
                  if (!ok2 || c !== 1'(g) || cid !== 6'(id)) begin
                     errors++;
                     $display("[TB] FAIL rand_handoff[%0d]: got ok=%0d ctx=%0d id=%0d expected ok=1 ctx=%0d id=%0d",
                              n, ok2, c, cid, g, id);
                  end
               end
            end
         end
         checks++;
         if (ctx_busy !== {busy_m[1], busy_m[0]} || bus_err !== err_m || spurious_cnt !== 8'(spur_m)) begin
            errors++;
            $display("[TB] FAIL rand_status[%0d]: got busy=%b err=%b cnt=%0d expected busy=%b err=%b cnt=%0d",
                     n, ctx_busy, bus_err, spurious_cnt, {busy_m[1], busy_m[0]}, err_m, spur_m);
         end
      end
   endtask

   initial begin
      test_reset;
      test_single_claim;
      test_complete;
      test_round_robin;
      test_spurious;
      test_bus_err;
      test_reset_mid;
      test_random;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/plic_claim_sequencer.md
PLIC_CLAIM_SEQUENCER -- requirements
Module: plic_claim_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 28: AXI address width.
REQ-002 SHALL have parameter PLIC_BASE, default 28'h0000000: PLIC base address on the bus.
REQ-003 SHALL have parameter CTX_STRIDE, default 28'h1000: per-context register block stride.
REQ-004 SHALL have ports (name  direction  width  meaning), clock and reset first:
- M_AXI_ACLK  in  1  clock.
- M_AXI_ARESET  in  1  synchronous reset, active-high.
- irq_ctx  in  2  PLIC context interrupt lines: bit0 = auto_int_out_0_0, bit1 = auto_int_out_1_0.
- M_AXI_AWADDR/AWVALID/AWREADY  out/out/in  ADDR_W/1/1  write address channel.
- M_AXI_WDATA/WSTRB/WVALID/WREADY  out/out/out/in  64/8/1/1  write data channel.
- M_AXI_BRESP/BVALID/BREADY  in/in/out  2/1/1  write response channel.
- M_AXI_ARADDR/ARVALID/ARREADY  out/out/in  ADDR_W/1/1  read address channel.
- M_AXI_RDATA/RRESP/RVALID/RREADY  in/in/in/out  64/2/1/1  read data channel.
- claim_valid/claim_ready  out/in  1/1  claimed-interrupt handoff to consumer.
- claim_ctx/claim_id  out/out  1/6  context and source ID of handoff.
- done_valid/done_ready  in/out  1/1  consumer completion request.
- done_ctx/done_id  in/in  1/6  context and ID to complete.
- ctx_busy  out  2  per-context claim outstanding (claimed, not yet completed).
- bus_err  out  1  sticky AXI error flag.
- spurious_cnt  out  8  count of claims returning ID 0.

Function
REQ-005 SHALL use FSM states IDLE, RD_ADDR, RD_DATA, HANDOFF, WR_REQ, WR_RESP; one bus transaction at a time.
REQ-006 In IDLE, a pending done_valid SHALL take priority over claims: go to WR_REQ next cycle, pulse done_ready for one cycle, latch done_ctx/done_id.
REQ-007 Otherwise, context c SHALL be eligible when irq_ctx[c]=1 and ctx_busy[c]=0; with one eligible, grant it; with both, grant round-robin (pointer = context not last granted; ctx0 wins after reset); go to RD_ADDR next cycle.
REQ-008 RD_ADDR: ARADDR = PLIC_BASE + 0x200000 + CTX_STRIDE*c + 4, ARVALID=1 held stable until ARREADY; then RD_DATA.
REQ-009 RD_DATA: RREADY=1; on RVALID, ID = RDATA[37:32].
REQ-010 On RVALID with RRESP!=0: set bus_err, no handoff, return to IDLE.
REQ-011 On RVALID with ID=0: increment spurious_cnt (saturating at 255), no handoff, return to IDLE.
REQ-012 On RVALID with ID!=0: set ctx_busy[c], go to HANDOFF.
REQ-013 HANDOFF: claim_valid=1 with claim_ctx/claim_id stable until claim_ready; then IDLE.
REQ-014 WR_REQ: AWADDR = PLIC_BASE + 0x200000 + CTX_STRIDE*done_ctx; WDATA = {26'b0, id, 32'b0}; WSTRB = 8'hF0.
REQ-015 AWVALID and WVALID SHALL assert together; each deasserts independently once its READY is seen; advance to WR_RESP when both have completed, whatever their order.
REQ-016 WR_RESP: BREADY=1; on BVALID clear ctx_busy[done_ctx], set bus_err if BRESP!=0, return to IDLE.
REQ-017 A completion for a context with ctx_busy=0 SHALL still be written to the PLIC.
REQ-018 Handshake timing: a VALID SHALL never depend combinationally on its READY; a transfer occurs on the edge where VALID and READY are both 1.
REQ-019 Minimum latencies: IDLE grant to ARVALID = 1 cycle; RVALID to claim_valid = 1 cycle; done_valid to AWVALID/WVALID = 1 cycle.

Reset
REQ-020 On M_AXI_ARESET=1 at a clock edge: state IDLE; all VALID/READY outputs 0; ctx_busy=0; bus_err=0; spurious_cnt=0; round-robin pointer to ctx0; address/data outputs 0.
REQ-021 Reset mid-transaction SHALL abandon the transaction with no handoff and no completion.

Verification
REQ-022 irq_ctx=01, RDATA=64'h0000000E_00000000 -> ARADDR 0x200004; claim_valid with ctx0/id14; ctx_busy=01.
REQ-023 done_valid ctx0 id14 -> AWADDR 0x200000, WDATA 64'h0000000E_00000000, WSTRB F0; ctx_busy=00 after BVALID.
REQ-024 irq_ctx=11 from reset, both return id 3 -> ctx0 read (0x200004), then ctx1 read (0x201004); ctx_busy=11.
REQ-025 Claim returns ID 0 -> no claim_valid; spurious_cnt=1.
REQ-026 RRESP=2'b10 on claim read -> bus_err=1, no claim_valid; WREADY before AWREADY on a completion -> exactly one AW and one W transfer.
REQ-027 Reset asserted during RD_DATA -> next cycle all valids 0, ctx_busy=00, state IDLE.
